// File: rtl/predecode_interrupt_unit.sv
// 6502 front end: latches the fetched byte into PD, pre-decodes it, and
// synchronises/polls NMI and IRQ so the controller can enter the BRK sequence.
module predecode_interrupt_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clock,
  input  logic       rst,
  input  logic       clk_ph1,
  input  logic       clk_ph2,
  input  logic [7:0] data_in,
  input  logic       rdy,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic       last_cycle,
  input  logic [2:0] cycle,
  input  logic       vec_done,
  output logic [7:0] PD,
  output logic       int_flag,
  output logic [1:0] int_type,
  output logic       nmi_pending,
  output logic       one_byte,
  output logic       two_cycle
);

  localparam logic [1:0] T_NONE = 2'd0, T_IRQ = 2'd1, T_NMI = 2'd2, T_RST = 2'd3;

  logic [SYNC_STAGES-1:0] r_nmi_sync, r_irq_sync;
  logic                   r_nmi_prev;
  logic [7:0]             r_pd;
  logic                   r_int_flag, r_nmi_pending;
  logic [1:0]             r_int_type;

  logic w_nmi_s, w_irq_s, w_irq_req, w_nmi_edge, w_nmi_any;
  logic w_poll, w_hijack, w_done, w_nmi_clr;
  logic w_imm, w_one_byte, w_two_cycle;

  assign w_nmi_s    = r_nmi_sync[SYNC_STAGES-1];
  assign w_irq_s    = r_irq_sync[SYNC_STAGES-1];
  assign w_irq_req  = !w_irq_s && !i_flag;
  assign w_nmi_edge = clk_ph2 && r_nmi_prev && !w_nmi_s;
  // An edge caught on the polling ph2 itself must already count as pending.
  assign w_nmi_any  = r_nmi_pending || w_nmi_edge;
  assign w_poll     = clk_ph2 && last_cycle && !r_int_flag;
  assign w_hijack   = clk_ph2 && r_int_flag && (r_int_type == T_IRQ) && r_nmi_pending
                      && (cycle <= 3'd4);
  // A software BRK runs with int_flag low, so its vec_done must not touch state.
  assign w_done     = clk_ph1 && vec_done && r_int_flag;
  assign w_nmi_clr  = clk_ph1 && vec_done && (r_int_type == T_NMI);

  always_ff @(posedge sys_clock) begin
    if (!rst) begin
      r_nmi_sync    <= '1;
      r_irq_sync    <= '1;
      r_nmi_prev    <= 1'b1;
      r_pd          <= 8'h00;
      r_int_flag    <= 1'b1;
      r_int_type    <= T_RST;
      r_nmi_pending <= 1'b0;
    end else begin
      r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_n};
      r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_n};
      if (clk_ph2) r_nmi_prev <= w_nmi_s;
      if (clk_ph2 && rdy) r_pd <= data_in;

      if (w_nmi_edge)     r_nmi_pending <= 1'b1;
      else if (w_nmi_clr) r_nmi_pending <= 1'b0;

      if (w_poll) begin
        r_int_flag <= w_nmi_any || w_irq_req;
        r_int_type <= w_nmi_any ? T_NMI : (w_irq_req ? T_IRQ : T_NONE);
      end else if (w_hijack) begin
        r_int_type <= T_NMI;
      end else if (w_done) begin
        r_int_flag <= 1'b0;
        r_int_type <= T_NONE;
      end
    end
  end

  // Pre-decode is blanked during an interrupt sequence since PD is not the opcode.
  always_comb begin
    w_one_byte  = 1'b0;
    w_imm       = 1'b0;
    w_two_cycle = 1'b0;
    if (!r_int_flag) begin
      w_one_byte  = (r_pd[3:0] == 4'h8) || (r_pd[3:0] == 4'hA);
      w_imm       = (r_pd[4:0] == 5'b01001) || (r_pd[7] && (r_pd[4:0] == 5'b00000));
      w_two_cycle = w_imm || (w_one_byte &&
                    !((r_pd[3:0] == 4'h8) && !r_pd[7] && !r_pd[4]));
    end
  end

  assign PD          = r_pd;
  assign int_flag    = r_int_flag;
  assign int_type    = r_int_type;
  assign nmi_pending = r_nmi_pending;
  assign one_byte    = w_one_byte;
  assign two_cycle   = w_two_cycle;

endmodule

// File: tb/tb_predecode_interrupt_unit.sv
// Bench for predecode_interrupt_unit: directed scenarios plus random traffic,
// every cycle checked against a behavioural model of the front end.
module tb_predecode_interrupt_unit;
  localparam int S = 2;

  logic       sys_clock = 1'b0;
  logic       rst = 1'b0, clk_ph1 = 1'b0, clk_ph2 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rdy = 1'b0, nmi_n = 1'b1, irq_n = 1'b1, i_flag = 1'b1;
  logic       last_cycle = 1'b0, vec_done = 1'b0;
  logic [2:0] cycle = 3'd0;
  logic [7:0] PD;
  logic       int_flag, nmi_pending, one_byte, two_cycle;
  logic [1:0] int_type;

  predecode_interrupt_unit #(.SYNC_STAGES(S)) dut (
    .sys_clock(sys_clock), .rst(rst), .clk_ph1(clk_ph1), .clk_ph2(clk_ph2),
    .data_in(data_in), .rdy(rdy), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
    .last_cycle(last_cycle), .cycle(cycle), .vec_done(vec_done), .PD(PD),
    .int_flag(int_flag), .int_type(int_type), .nmi_pending(nmi_pending),
    .one_byte(one_byte), .two_cycle(two_cycle));

  always #5 sys_clock = ~sys_clock;

  int n_cmp = 0, n_bad = 0;

  // Model state: pin history stands in for the synchroniser chain.
  logic [7:0] m_pd;
  logic       m_flag, m_pend, m_prev, m_valid = 1'b0;
  logic [1:0] m_type;
  logic       h_nmi[S], h_irq[S];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_one_byte(input logic [7:0] op);
    return (op[3:0] == 4'h8) || (op[3:0] == 4'hA);
  endfunction

  function automatic logic is_two_cycle(input logic [7:0] op);
    logic imm;
    imm = op inside {8'h09, 8'h29, 8'h49, 8'h69, 8'h89, 8'hA9, 8'hC9, 8'hE9,
                     8'h80, 8'hA0, 8'hC0, 8'hE0};
    return imm || (is_one_byte(op) && !(op inside {8'h08, 8'h28, 8'h48, 8'h68}));
  endfunction

  task automatic model_step();
    logic nmi_s, irq_req, edge_now, pend_now;
    if (!rst) begin
      m_pd = 8'h00; m_flag = 1'b1; m_type = 2'd3; m_pend = 1'b0; m_prev = 1'b1;
      for (int i = 0; i < S; i++) begin h_nmi[i] = 1'b1; h_irq[i] = 1'b1; end
      m_valid = 1'b1;
      return;
    end
    nmi_s    = h_nmi[S-1];
    irq_req  = !h_irq[S-1] && !i_flag;
    edge_now = clk_ph2 && m_prev && !nmi_s;
    pend_now = m_pend || edge_now;
    if (clk_ph2 && last_cycle && !m_flag) begin
      m_flag = pend_now || irq_req;
      m_type = pend_now ? 2'd2 : (irq_req ? 2'd1 : 2'd0);
    end else if (clk_ph2 && m_flag && m_type == 2'd1 && m_pend && cycle <= 3'd4) begin
      m_type = 2'd2;
    end else if (clk_ph1 && vec_done && m_flag) begin
      if (m_type == 2'd2) m_pend = 1'b0;
      m_flag = 1'b0; m_type = 2'd0;
    end
    if (edge_now) m_pend = 1'b1;
    if (clk_ph2) m_prev = nmi_s;
    if (clk_ph2 && rdy) m_pd = data_in;
    for (int i = S-1; i > 0; i--) begin h_nmi[i] = h_nmi[i-1]; h_irq[i] = h_irq[i-1]; end
    h_nmi[0] = nmi_n; h_irq[0] = irq_n;
  endtask

  // One sys_clock: model advances on the edge, DUT compared at the negedge.
  task automatic tick(input logic p1, input logic p2);
    clk_ph1 = p1; clk_ph2 = p2;
    @(posedge sys_clock);
    model_step();
    @(negedge sys_clock);
    if (m_valid) begin
      chk("PD", PD, m_pd);
      chk("int_flag", {7'd0, int_flag}, {7'd0, m_flag});
      chk("int_type", {6'd0, int_type}, {6'd0, m_type});
      chk("nmi_pending", {7'd0, nmi_pending}, {7'd0, m_pend});
      chk("one_byte", {7'd0, one_byte}, {7'd0, !m_flag && is_one_byte(m_pd)});
      chk("two_cycle", {7'd0, two_cycle}, {7'd0, !m_flag && is_two_cycle(m_pd)});
    end
    clk_ph1 = 1'b0; clk_ph2 = 1'b0;
  endtask

  task automatic ph(input int p);
    tick(p == 1, p == 2);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    // Reset with garbage on the bus
    rst = 1'b0; data_in = 8'hEA; rdy = 1'b1;
    repeat (3) tick(1'b0, 1'b1);
    chk("rst_PD", PD, 8'h00);
    chk("rst_flag", {7'd0, int_flag}, 8'd1);
    chk("rst_type", {6'd0, int_type}, 8'd3);
    rst = 1'b1; vec_done = 1'b1; ph(1); vec_done = 1'b0;
    chk("rst_done_flag", {7'd0, int_flag}, 8'd0);
    chk("rst_done_type", {6'd0, int_type}, 8'd0);

    // PD load and predecode
    rdy = 1'b1; data_in = 8'hA9; ph(2);
    chk("pd_A9", PD, 8'hA9);
    chk("A9_two", {7'd0, two_cycle}, 8'd1);
    chk("A9_one", {7'd0, one_byte}, 8'd0);
    data_in = 8'h48; ph(2);
    chk("48_one", {7'd0, one_byte}, 8'd1);
    chk("48_two", {7'd0, two_cycle}, 8'd0);
    rdy = 1'b0; data_in = 8'h00; ph(2);
    chk("pd_hold", PD, 8'h48);
    rdy = 1'b1;

    // IRQ masked then taken
    irq_n = 1'b0; i_flag = 1'b1; ph(0); ph(0);
    last_cycle = 1'b1; ph(2);
    chk("irq_masked", {7'd0, int_flag}, 8'd0);
    i_flag = 1'b0; ph(2);
    chk("irq_flag", {7'd0, int_flag}, 8'd1);
    chk("irq_type", {6'd0, int_type}, 8'd1);
    last_cycle = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
    vec_done = 1'b1; ph(1); vec_done = 1'b0;

    // NMI edge, held low afterwards: only one service
    nmi_n = 1'b0; ph(1); ph(2);
    chk("nmi_pend", {7'd0, nmi_pending}, 8'd1);
    last_cycle = 1'b1; ph(2);
    chk("nmi_type", {6'd0, int_type}, 8'd2);
    last_cycle = 1'b0; vec_done = 1'b1; ph(1); vec_done = 1'b0;
    chk("nmi_clr", {7'd0, nmi_pending}, 8'd0);
    last_cycle = 1'b1; ph(2);
    chk("nmi_no_repeat", {7'd0, int_flag}, 8'd0);
    last_cycle = 1'b0; nmi_n = 1'b1; ph(1); ph(2); ph(2);

    // Hijack inside the window
    irq_n = 1'b0; i_flag = 1'b0; ph(0); last_cycle = 1'b1; ph(2);
    last_cycle = 1'b0; cycle = 3'd3;
    nmi_n = 1'b0; ph(1); ph(2); ph(2);
    chk("hijack", {6'd0, int_type}, 8'd2);
    vec_done = 1'b1; ph(1); vec_done = 1'b0;
    irq_n = 1'b1; nmi_n = 1'b1; ph(2); ph(2);

    // Too late to hijack: NMI stays pending for the next poll
    irq_n = 1'b0; ph(0); last_cycle = 1'b1; ph(2);
    last_cycle = 1'b0; cycle = 3'd6;
    nmi_n = 1'b0; ph(1); ph(2); ph(2);
    chk("no_hijack_type", {6'd0, int_type}, 8'd1);
    chk("no_hijack_pend", {7'd0, nmi_pending}, 8'd1);
    vec_done = 1'b1; ph(1); vec_done = 1'b0;
    irq_n = 1'b1; last_cycle = 1'b1; ph(2);
    chk("repoll_nmi", {6'd0, int_type}, 8'd2);
    last_cycle = 1'b0;

    // Reset mid-sequence
    rst = 1'b0; tick(1'b0, 1'b0);
    chk("mrst_type", {6'd0, int_type}, 8'd3);
    chk("mrst_pend", {7'd0, nmi_pending}, 8'd0);
    chk("mrst_pd", PD, 8'h00);
    rst = 1'b1; nmi_n = 1'b1;

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      int p;
      rst        = ($urandom_range(0, 299) != 0);
      data_in    = 8'($urandom);
      rdy        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
      if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
      i_flag     = ($urandom_range(0, 2) == 0);
      last_cycle = ($urandom_range(0, 2) == 0);
      cycle      = 3'($urandom_range(0, 7));
      vec_done   = ($urandom_range(0, 3) == 0);
      p = $urandom_range(0, 3);
      tick(p == 1, p == 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
